// File: rtl/mac_adain_seq_if.sv
// Handshake and MAC-operand bundle for the AdaIN statistics sequencer.
// The master side streams elements and owns the external MAC; the slave is the sequencer.
interface mac_adain_seq_if #(
    parameter int WIDTH_IN  = 48,
    parameter int WIDTH_OUT = 112,
    parameter int LEN_W     = 16
);
    logic                 start;
    logic [LEN_W-1:0]     cfg_len;
    logic                 in_valid;
    logic [WIDTH_IN-1:0]  in_data;
    logic                 in_ready;
    logic                 pass;
    logic                 busy;
    logic                 done;
    logic                 err_len;
    logic [WIDTH_IN-1:0]  mac_multiplicand;
    logic [WIDTH_IN-1:0]  mac_multiplier;
    logic [WIDTH_IN-1:0]  mac_offset;
    logic                 mac_rst_acc;
    logic [WIDTH_OUT-1:0] mac_acc;
    logic [WIDTH_OUT-1:0] sum_out;
    logic [WIDTH_OUT-1:0] sumsq_out;

    modport master (
        output start, cfg_len, in_valid, in_data, mac_acc,
        input  in_ready, pass, busy, done, err_len,
        input  mac_multiplicand, mac_multiplier, mac_offset, mac_rst_acc,
        input  sum_out, sumsq_out
    );

    modport slave (
        input  start, cfg_len, in_valid, in_data, mac_acc,
        output in_ready, pass, busy, done, err_len,
        output mac_multiplicand, mac_multiplier, mac_offset, mac_rst_acc,
        output sum_out, sumsq_out
    );
endinterface

// File: rtl/mac_adain_seq.sv
// Two-pass sequencer feeding an external MAC: pass 0 accumulates sum(x),
// pass 1 accumulates sum(x*x); each result is captured once the MAC pipeline drains.
module mac_adain_seq #(
    parameter int WIDTH_IN     = 48,
    parameter int FRAC_BITS_IN = 16,
    parameter int WIDTH_OUT    = 112,
    parameter int LEN_W        = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    mac_adain_seq_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SUM    = 3'd1,
        DRAIN0 = 3'd2,
        SUMSQ  = 3'd3,
        DRAIN1 = 3'd4,
        FIN    = 3'd5
    } state_t;

    localparam logic [WIDTH_IN-1:0] ONE = WIDTH_IN'(1) << FRAC_BITS_IN;

    state_t               state, state_nxt;
    logic [LEN_W-1:0]     n_lat;
    logic [LEN_W-1:0]     cnt;
    logic [1:0]           dcnt;
    logic                 first_q;
    logic                 err_len_q;
    logic                 mac_rst_acc_q;
    logic [WIDTH_IN-1:0]  mcand_q;
    logic [WIDTH_IN-1:0]  mplier_q;
    logic [WIDTH_OUT-1:0] sum_q;
    logic [WIDTH_OUT-1:0] sumsq_q;

    logic in_ready_c;
    logic accept;
    logic last_accept;
    logic drain_done;
    logic start_ok;
    logic in_drain;

    always_comb begin
        in_ready_c = 1'b0;
        if ((state == SUM) || (state == SUMSQ))
            in_ready_c = (cnt < n_lat);
    end

    assign accept      = in_ready_c && bus.in_valid;
    assign last_accept = accept && (cnt == (n_lat - LEN_W'(1)));
    // Capture lands three edges after the last accept: operand reg, product reg, accumulator.
    assign drain_done  = (dcnt == 2'd2);
    assign in_drain    = (state == DRAIN0) || (state == DRAIN1);
    assign start_ok    = (state == IDLE) && bus.start && (bus.cfg_len != '0);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_ok)    state_nxt = SUM;
            SUM:     if (last_accept) state_nxt = DRAIN0;
            DRAIN0:  if (drain_done)  state_nxt = SUMSQ;
            SUMSQ:   if (last_accept) state_nxt = DRAIN1;
            DRAIN1:  if (drain_done)  state_nxt = FIN;
            FIN:                      state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            n_lat         <= '0;
            cnt           <= '0;
            dcnt          <= '0;
            first_q       <= 1'b0;
            err_len_q     <= 1'b0;
            mac_rst_acc_q <= 1'b0;
            mcand_q       <= '0;
            mplier_q      <= '0;
            sum_q         <= '0;
            sumsq_q       <= '0;
        end else begin
            state     <= state_nxt;
            err_len_q <= (state == IDLE) && bus.start && (bus.cfg_len == '0);

            if (start_ok) begin
                n_lat <= bus.cfg_len;
                cnt   <= '0;
            end else if (accept) begin
                cnt <= cnt + LEN_W'(1);
            end else if ((state == DRAIN0) && drain_done) begin
                cnt <= '0;
            end

            dcnt <= in_drain ? (dcnt + 2'd1) : 2'd0;

            // Bubbles drive zero operands so idle cycles add nothing to the accumulator.
            mcand_q  <= accept ? bus.in_data : '0;
            mplier_q <= accept ? ((state == SUMSQ) ? bus.in_data : ONE) : '0;

            // Accumulator load is delayed one edge to line up with the MAC product register.
            first_q       <= accept && (cnt == '0);
            mac_rst_acc_q <= first_q;

            if ((state == DRAIN0) && drain_done)
                sum_q <= bus.mac_acc;
            if ((state == DRAIN1) && drain_done)
                sumsq_q <= bus.mac_acc;
        end
    end

    assign bus.in_ready         = in_ready_c;
    assign bus.busy             = (state != IDLE);
    assign bus.pass             = (state == SUMSQ) || (state == DRAIN1) || (state == FIN);
    assign bus.done             = (state == FIN);
    assign bus.err_len          = err_len_q;
    assign bus.mac_multiplicand = mcand_q;
    assign bus.mac_multiplier   = mplier_q;
    assign bus.mac_offset       = '0;
    assign bus.mac_rst_acc      = mac_rst_acc_q;
    assign bus.sum_out          = sum_q;
    assign bus.sumsq_out        = sumsq_q;
endmodule

// File: tb/tb_mac_adain_seq.sv
// Bench for mac_adain_seq: behavioural two-stage MAC, directed jobs,
// scoreboard of expected sum / sum-of-squares popped on each done pulse.
module tb_mac_adain_seq;
    localparam int WI = 48;
    localparam int FB = 16;
    localparam int WO = 112;
    localparam int LW = 16;

    typedef struct {
        logic [WO-1:0] s;
        logic [WO-1:0] q;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mac_adain_seq_if #(.WIDTH_IN(WI), .WIDTH_OUT(WO), .LEN_W(LW)) bus ();

    mac_adain_seq #(
        .WIDTH_IN(WI), .FRAC_BITS_IN(FB), .WIDTH_OUT(WO), .LEN_W(LW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // External MAC: product register then accumulator; never reset, so stale state persists.
    logic signed [2*WI-1:0] prod = '0;
    logic        [WO-1:0]   acc  = 112'h5A5A_0000_1234_5678_9ABC_DEF0;
    always @(posedge clk) begin
        prod <= $signed(bus.mac_multiplicand) * $signed(bus.mac_multiplier);
        acc  <= (bus.mac_rst_acc ? '0 : acc) + {{(WO-2*WI){prod[2*WI-1]}}, prod}
                + {{(WO-WI){bus.mac_offset[WI-1]}}, bus.mac_offset};
    end
    assign bus.mac_acc = acc;

    task automatic chk(input string tag, input logic [WO-1:0] obs, input logic [WO-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_accept();
        int t = 0;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                return;
            end
            t++;
            if (t > 40) begin
                chk("accept_timeout", bus.in_ready, 1'b1);
                return;
            end
        end
    endtask

    task automatic wait_done();
        exp_t e;
        bit   seen = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk("done_timeout", bus.done, 1'b1);
        end else if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sum_out", bus.sum_out, e.s);
            chk("sumsq_out", bus.sumsq_out, e.q);
            @(negedge clk);
            chk("done_one_cycle", bus.done, 1'b0);
            chk("busy_after", bus.busy, 1'b0);
        end
    endtask

    task automatic run_job(input int n, input logic [WI-1:0] d[4], input bit gaps, input bit poke);
        exp_t e;
        logic signed [WO-1:0] xe;
        e.s = '0;
        e.q = '0;
        for (int i = 0; i < n; i++) begin
            xe  = {{(WO-WI){d[i][WI-1]}}, d[i]};
            e.s = e.s + (xe <<< FB);
            e.q = e.q + (xe * xe);
        end
        sb.push_back(e);
        bus.start   = 1'b1;
        bus.cfg_len = LW'(n);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < n; i++) begin
                if (gaps && (i % 2 == 1)) begin
                    bus.in_valid = 1'b0;
                    repeat (2) @(posedge clk);
                    #1;
                end
                bus.in_valid = 1'b1;
                bus.in_data  = d[i];
                if (poke && p == 0 && i == 1) begin
                    bus.start   = 1'b1;
                    bus.cfg_len = LW'(1);
                end
                wait_accept();
                bus.start    = 1'b0;
                bus.in_valid = 1'b0;
            end
            bus.in_valid = 1'b1;
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                chk("in_ready_after_last", bus.in_ready, 1'b0);
            end
            chk("pass_flag", bus.pass, WO'(p));
            bus.in_valid = 1'b0;
        end
        wait_done();
    endtask

    logic [WI-1:0] d1[4];
    logic [WI-1:0] d2[4];
    logic [WI-1:0] d3[4];
    logic [WI-1:0] d4[4];
    logic [WO-1:0] s_keep;
    logic [WO-1:0] q_keep;

    initial begin
        bus.start    = 1'b0;
        bus.cfg_len  = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        d1 = '{WI'(65536), WI'(131072), WI'(196608), WI'(262144)};
        d2 = '{WI'(-98304), WI'(-98304), WI'(0), WI'(0)};
        d3 = '{WI'(131072), WI'(0), WI'(0), WI'(0)};
        d4 = '{WI'(196608), WI'(0), WI'(0), WI'(0)};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_sum", bus.sum_out, '0);
        chk("rst_offset", bus.mac_offset, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_job(4, d1, 1'b0, 1'b0);
        chk("sum_const_10", bus.sum_out, WO'(10) << 32);
        chk("sumsq_const_30", bus.sumsq_out, WO'(30) << 32);

        run_job(4, d1, 1'b1, 1'b1);

        run_job(2, d2, 1'b0, 1'b0);
        chk("sum_neg_const", bus.sum_out, '0 - (WO'(3) << 32));
        chk("sumsq_4p5_const", bus.sumsq_out, WO'(9) << 31);

        s_keep = bus.sum_out;
        q_keep = bus.sumsq_out;
        bus.start   = 1'b1;
        bus.cfg_len = '0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("err_len_pulse", bus.err_len, 1'b1);
        chk("err_busy", bus.busy, 1'b0);
        @(negedge clk);
        chk("err_len_clear", bus.err_len, 1'b0);
        chk("err_busy_2", bus.busy, 1'b0);
        chk("err_sum_kept", bus.sum_out, s_keep);
        chk("err_sumsq_kept", bus.sumsq_out, q_keep);

        bus.start   = 1'b1;
        bus.cfg_len = LW'(4);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = d1[i % 4];
            wait_accept();
        end
        chk("pre_rst_pass", bus.pass, 1'b1);
        chk("pre_rst_busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("mid_rst_in_ready", bus.in_ready, 1'b0);
        chk("mid_rst_pass", bus.pass, 1'b0);
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_done", bus.done, 1'b0);
        chk("mid_rst_err_len", bus.err_len, 1'b0);
        chk("mid_rst_mcand", bus.mac_multiplicand, '0);
        chk("mid_rst_mplier", bus.mac_multiplier, '0);
        chk("mid_rst_rst_acc", bus.mac_rst_acc, 1'b0);
        chk("mid_rst_sum", bus.sum_out, '0);
        chk("mid_rst_sumsq", bus.sumsq_out, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_job(4, d1, 1'b0, 1'b0);

        run_job(1, d3, 1'b0, 1'b0);
        run_job(1, d4, 1'b0, 1'b0);
        chk("b2b_sum_3", bus.sum_out, WO'(3) << 32);
        chk("b2b_sumsq_9", bus.sumsq_out, WO'(9) << 32);
        chk("sb_empty", WO'(sb.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
